// File: rtl/int_root_seq.sv
// int_root_seq: sequential integer square / cube root.
// One result digit per clock, MSB group first, using the classic
// digit-by-digit restoring method. The cube-mode trial value is built from
// an incrementally maintained root^2 term, so no multiplier is needed.
module int_root_seq #(
   parameter int WIDTH = 32,
   parameter int RW    = (WIDTH + 1) / 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    out_root,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_mode
);

   // Digit-group counts per mode and the padded radicand width.
   localparam int G_SQ = (WIDTH + 1) / 2;
   localparam int G_CB = (WIDTH + 2) / 3;
   localparam int SW   = (2 * G_SQ > 3 * G_CB) ? 2 * G_SQ : 3 * G_CB;
   // Working width for rem/trial/root^2: a few bits of headroom above
   // WIDTH covers the shifted remainder and 12*root^2 for every legal WIDTH.
   localparam int RMW  = WIDTH + 6;
   localparam int CW   = $clog2(G_SQ) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [SW-1:0]    shift_q, shift_d;
   logic [RMW-1:0]   rem_q, rem_d;
   logic [RW-1:0]    root_q, root_d;
   logic [RMW-1:0]   sq_q, sq_d;
   logic [RW-1:0]    out_root_q, out_root_d;
   logic [WIDTH-1:0] out_rem_q, out_rem_d;
   logic             out_mode_q, out_mode_d;

   logic [RMW-1:0]   digit;
   logic [RMW-1:0]   root_x;
   logic [RMW-1:0]   rem_sh;
   logic [RMW-1:0]   trial;
   logic             accept;
   logic [RMW-1:0]   rem_n;
   logic [RW-1:0]    root_n;
   logic [RMW-1:0]   sq_n;
   logic [SW-1:0]    shift_n;
   logic [SW-1:0]    load_shift;

   // One digit step: shift in the next group, form the trial, accept or reject.
   always_comb begin
      digit  = mode_q ? RMW'(shift_q[SW-1 -: 3]) : RMW'(shift_q[SW-1 -: 2]);
      root_x = RMW'(root_q);
      rem_sh = mode_q ? ((rem_q << 3) | digit) : ((rem_q << 2) | digit);
      // Cube trial 12*r^2 + 6*r + 1 from shifts and adds only.
      trial  = mode_q ? ((sq_q << 3) + (sq_q << 2) + (root_x << 2) + (root_x << 1) + RMW'(1))
                      : ((root_x << 2) + RMW'(1));
      accept = (rem_sh >= trial);
      rem_n  = accept ? (rem_sh - trial) : rem_sh;
      root_n = {root_q[RW-2:0], accept};
      // (2r+1)^2 = 4r^2 + 4r + 1, (2r)^2 = 4r^2
      sq_n   = accept ? ((sq_q << 2) + (root_x << 2) + RMW'(1)) : (sq_q << 2);
      shift_n = mode_q ? (shift_q << 3) : (shift_q << 2);
      // Left-align the radicand so the first group sits at the top of shift_q.
      load_shift = in_mode ? (SW'(in_data) << (SW - 3 * G_CB))
                           : (SW'(in_data) << (SW - 2 * G_SQ));
   end

   // Control FSM and next-state selection for all registers.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      shift_d    = shift_q;
      rem_d      = rem_q;
      root_d     = root_q;
      sq_d       = sq_q;
      out_root_d = out_root_q;
      out_rem_d  = out_rem_q;
      out_mode_d = out_mode_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mode_d  = in_mode;
               shift_d = load_shift;
               rem_d   = '0;
               root_d  = '0;
               sq_d    = '0;
               cnt_d   = in_mode ? CW'(G_CB - 1) : CW'(G_SQ - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            shift_d = shift_n;
            rem_d   = rem_n;
            root_d  = root_n;
            sq_d    = sq_n;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               out_root_d = root_n;
               out_rem_d  = rem_n[WIDTH-1:0];
               out_mode_d = mode_q;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         shift_q    <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         sq_q       <= '0;
         out_root_q <= '0;
         out_rem_q  <= '0;
         out_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         shift_q    <= shift_d;
         rem_q      <= rem_d;
         root_q     <= root_d;
         sq_q       <= sq_d;
         out_root_q <= out_root_d;
         out_rem_q  <= out_rem_d;
         out_mode_q <= out_mode_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_root  = out_root_q;
   assign out_rem   = out_rem_q;
   assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_int_root_seq.sv
// tb_int_root_seq: directed and randomized checks of int_root_seq at
// WIDTH=32 and WIDTH=8 against a bisection-search reference model.
module tb_int_root_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
   logic [31:0] a_in_data, a_out_rem;
   logic [15:0] a_out_root;

   logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
   logic [7:0]  b_in_data, b_out_rem;
   logic [3:0]  b_out_root;

   int total = 0;
   int bad   = 0;

   typedef struct {
      longint unsigned x;
      bit              m;
   } op_t;

   op_t qa[$];
   op_t qb[$];

   int_root_seq #(.WIDTH(32)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_root(a_out_root), .out_rem(a_out_rem), .out_mode(a_out_mode)
   );

   int_root_seq #(.WIDTH(8)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_root(b_out_root), .out_rem(b_out_rem), .out_mode(b_out_mode)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned kpow(input longint unsigned r, input bit cube);
      return cube ? r * r * r : r * r;
   endfunction

   // Largest r with r^k <= x, by bisection (hi^k always exceeds any 32-bit x).
   function automatic longint unsigned ref_root(input longint unsigned x, input bit cube);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = cube ? 64'd4096 : 64'd65536;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (kpow(mid, cube) <= x) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   task automatic check_result(input string tag, input longint unsigned x, input bit cube,
                               input longint unsigned root, input longint unsigned rem);
      longint unsigned r;
      r = ref_root(x, cube);
      chk({tag, "_root"}, root, r);
      chk({tag, "_rem"}, rem, x - kpow(r, cube));
      chk({tag, "_bracket"}, 64'((kpow(root, cube) <= x) && (kpow(root + 1, cube) > x)), 64'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one op to the 32-bit instance; optionally wiggle in_valid/in_mode while busy.
   task automatic op_a(input logic [31:0] x, input logic m, input int exp_lat, input bit disturb,
                       output logic [15:0] root, output logic [31:0] rem, output logic mo);
      int n;
      chk("a_ready_before_op", 64'(a_in_ready), 64'd1);
      a_in_valid = 1'b1;
      a_in_data  = x;
      a_in_mode  = m;
      tick();
      a_in_valid = 1'b0;
      n = 0;
      while (!a_out_valid && n < 200) begin
         if (disturb) begin
            a_in_valid = 1'b1;
            a_in_mode  = ~m;
            a_in_data  = $urandom;
         end
         tick();
         n++;
      end
      a_in_valid = 1'b0;
      chk("a_latency", 64'(n), 64'(exp_lat));
      root = a_out_root;
      rem  = a_out_rem;
      mo   = a_out_mode;
   endtask

   task automatic op_b(input logic [7:0] x, input logic m, input int exp_lat,
                       output logic [3:0] root, output logic [7:0] rem, output logic mo);
      int n;
      chk("b_ready_before_op", 64'(b_in_ready), 64'd1);
      b_in_valid = 1'b1;
      b_in_data  = x;
      b_in_mode  = m;
      tick();
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 200) begin
         tick();
         n++;
      end
      chk("b_latency", 64'(n), 64'(exp_lat));
      root = b_out_root;
      rem  = b_out_rem;
      mo   = b_out_mode;
   endtask

   function automatic logic [31:0] pick_a(input bit m);
      longint unsigned r;
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return 32'($urandom_range(0, 100));
         2: return 32'hFFFF_FFFF;
         default: begin
            r = m ? 64'($urandom_range(0, 1625)) : 64'($urandom_range(0, 65535));
            return 32'(kpow(r, m));
         end
      endcase
   endfunction

   initial begin
      logic [15:0] ar;
      logic [31:0] am;
      logic        amo;
      logic [3:0]  br;
      logic [7:0]  bm;
      logic        bmo;
      int          nv;
      int          pops_a, pops_b;
      bit          acc_a, acc_b, pop_a, pop_b;
      op_t         e;

      reset_n     = 1'b0;
      a_in_valid  = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_out_ready = 1'b0;
      b_in_valid  = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_out_ready = 1'b0;
      repeat (2) tick();

      // Reset state
      chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_out_root", 64'(a_out_root), 64'd0);
      chk("rst_a_out_rem", 64'(a_out_rem), 64'd0);
      chk("rst_a_out_mode", 64'(a_out_mode), 64'd0);
      chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
      chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      reset_n = 1'b1;
      tick();

      // Cube 27, immediate handshake
      a_out_ready = 1'b1;
      op_a(32'd27, 1'b1, 11, 1'b0, ar, am, amo);
      chk("cube27_root", 64'(ar), 64'd3);
      chk("cube27_rem", 64'(am), 64'd0);
      chk("cube27_mode", 64'(amo), 64'd1);
      tick();
      chk("cube27_idle_valid", 64'(a_out_valid), 64'd0);
      chk("cube27_idle_ready", 64'(a_in_ready), 64'd1);

      // All-ones radicand in both modes
      op_a(32'hFFFF_FFFF, 1'b0, 16, 1'b0, ar, am, amo);
      chk("sq_max_root", 64'(ar), 64'd65535);
      chk("sq_max_rem", 64'(am), 64'd131070);
      chk("sq_max_mode", 64'(amo), 64'd0);
      tick();
      op_a(32'hFFFF_FFFF, 1'b1, 11, 1'b0, ar, am, amo);
      chk("cb_max_root", 64'(ar), 64'd1625);
      chk("cb_max_rem", 64'(am), 64'd3951670);
      tick();

      // Zero radicand still takes full latency
      op_a(32'd0, 1'b0, 16, 1'b0, ar, am, amo);
      chk("sq_zero_root", 64'(ar), 64'd0);
      chk("sq_zero_rem", 64'(am), 64'd0);
      tick();

      // Back-pressure: result held while out_ready=0, in_valid ignored
      a_out_ready = 1'b0;
      op_a(32'd26, 1'b0, 16, 1'b0, ar, am, amo);
      chk("sq26_root", 64'(ar), 64'd5);
      chk("sq26_rem", 64'(am), 64'd1);
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = $urandom;
         a_in_mode  = 1'($urandom);
         tick();
         chk("hold_valid", 64'(a_out_valid), 64'd1);
         chk("hold_root", 64'(a_out_root), 64'd5);
         chk("hold_rem", 64'(a_out_rem), 64'd1);
         chk("hold_in_ready", 64'(a_in_ready), 64'd0);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      tick();
      chk("hold_release_valid", 64'(a_out_valid), 64'd0);
      chk("hold_release_ready", 64'(a_in_ready), 64'd1);
      tick();
      chk("hold_no_ghost_op", 64'(a_in_ready), 64'd1);

      // Mode flips and in_valid while busy must not disturb the op
      op_a(32'd64, 1'b1, 11, 1'b1, ar, am, amo);
      chk("disturb_root", 64'(ar), 64'd4);
      chk("disturb_rem", 64'(am), 64'd0);
      chk("disturb_mode", 64'(amo), 64'd1);
      tick();

      // Reset in mid-operation aborts it
      a_in_valid = 1'b1;
      a_in_data  = 32'd1000;
      a_in_mode  = 1'b1;
      tick();
      a_in_valid = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      chk("abort_ready", 64'(a_in_ready), 64'd1);
      chk("abort_valid", 64'(a_out_valid), 64'd0);
      chk("abort_root", 64'(a_out_root), 64'd0);
      chk("abort_rem", 64'(a_out_rem), 64'd0);
      chk("abort_mode", 64'(a_out_mode), 64'd0);
      reset_n = 1'b1;
      nv = 0;
      repeat (15) begin
         tick();
         if (a_out_valid) nv++;
      end
      chk("abort_no_valid", 64'(nv), 64'd0);
      op_a(32'd1000, 1'b1, 11, 1'b0, ar, am, amo);
      chk("cube1000_root", 64'(ar), 64'd10);
      chk("cube1000_rem", 64'(am), 64'd0);
      tick();

      // Narrow instance
      b_out_ready = 1'b1;
      op_b(8'd255, 1'b1, 3, br, bm, bmo);
      chk("b_cb255_root", 64'(br), 64'd6);
      chk("b_cb255_rem", 64'(bm), 64'd39);
      chk("b_cb255_mode", 64'(bmo), 64'd1);
      tick();
      op_b(8'd255, 1'b0, 4, br, bm, bmo);
      chk("b_sq255_root", 64'(br), 64'd15);
      chk("b_sq255_rem", 64'(bm), 64'd30);
      tick();
      op_b(8'd0, 1'b1, 3, br, bm, bmo);
      chk("b_cb0_root", 64'(br), 64'd0);
      chk("b_cb0_rem", 64'(bm), 64'd0);
      tick();
      op_b(8'd0, 1'b0, 4, br, bm, bmo);
      chk("b_sq0_root", 64'(br), 64'd0);
      chk("b_sq0_rem", 64'(bm), 64'd0);
      tick();

      // Random regression with random valid/ready on both instances
      pops_a = 0;
      pops_b = 0;
      for (int c = 0; c < 4000; c++) begin
         a_in_mode   = 1'($urandom);
         a_in_data   = pick_a(a_in_mode);
         a_in_valid  = 1'($urandom);
         a_out_ready = 1'($urandom);
         b_in_mode   = 1'($urandom);
         b_in_data   = 8'($urandom);
         b_in_valid  = 1'($urandom);
         b_out_ready = 1'($urandom);
         acc_a = a_in_valid && a_in_ready;
         acc_b = b_in_valid && b_in_ready;
         pop_a = a_out_valid && a_out_ready;
         pop_b = b_out_valid && b_out_ready;
         if (pop_a) begin
            if (qa.size() == 0) chk("a_unexpected_result", 64'd1, 64'd0);
            else begin
               e = qa.pop_front();
               check_result("a_rand", e.x, e.m, 64'(a_out_root), 64'(a_out_rem));
               chk("a_rand_mode", 64'(a_out_mode), 64'(e.m));
               pops_a++;
            end
         end
         if (pop_b) begin
            if (qb.size() == 0) chk("b_unexpected_result", 64'd1, 64'd0);
            else begin
               e = qb.pop_front();
               check_result("b_rand", e.x, e.m, 64'(b_out_root), 64'(b_out_rem));
               chk("b_rand_mode", 64'(b_out_mode), 64'(e.m));
               pops_b++;
            end
         end
         if (acc_a) qa.push_back('{x: 64'(a_in_data), m: a_in_mode});
         if (acc_b) qb.push_back('{x: 64'(b_in_data), m: b_in_mode});
         tick();
      end

      // Drain whatever is still in flight
      a_in_valid  = 1'b0;
      b_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      for (int c = 0; c < 100 && (qa.size() != 0 || qb.size() != 0); c++) begin
         if (a_out_valid && qa.size() != 0) begin
            e = qa.pop_front();
            check_result("a_drain", e.x, e.m, 64'(a_out_root), 64'(a_out_rem));
            pops_a++;
         end
         if (b_out_valid && qb.size() != 0) begin
            e = qb.pop_front();
            check_result("b_drain", e.x, e.m, 64'(b_out_root), 64'(b_out_rem));
            pops_b++;
         end
         tick();
      end
      chk("a_queue_empty", 64'(qa.size()), 64'd0);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      chk("a_enough_ops", 64'(pops_a > 50), 64'd1);
      chk("b_enough_ops", 64'(pops_b > 50), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
